// File: rtl/block_xform_pkg.sv
// Shared types for the block transform engine: FSM state and element transform mode.
package block_xform_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    PROCESS = 4'd2,
    DONE    = 4'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_LSHIFT = 2'd2,
    MODE_ABS    = 2'd3
  } mode_t;

endpackage

// File: rtl/block_xform_unit.sv
// One-stage registered element transform; carries the element index alongside the
// result so the caller knows where to write it.
module block_xform_unit
  import block_xform_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LEVEL_OFFSET = 128,
  parameter int IDX_W        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mode_t             mode_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic              valid_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] y_o,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam logic [DATA_W-1:0] OFFSET = DATA_W'(LEVEL_OFFSET);

  logic [DATA_W-1:0] y_d, y_q;
  logic              valid_q;
  logic [IDX_W-1:0]  idx_q;

  // Negating the most-negative value wraps back onto itself, which is the intended abs result.
  always_comb begin
    y_d = x_i;
    unique case (mode_i)
      MODE_BYPASS: y_d = x_i;
      MODE_INVERT: y_d = ~x_i;
      MODE_LSHIFT: y_d = x_i - OFFSET;
      MODE_ABS:    y_d = x_i[DATA_W-1] ? -x_i : x_i;
      default:     y_d = x_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_i;
      y_q     <= y_d;
      idx_q   <= idx_i;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/block_xform_engine.sv
// Block engine: fetches DEPTH words from the source buffer, transforms each element
// through block_xform_unit and holds the results for address readback.
//
//   state   | meaning
//   IDLE    | waiting for a start rising edge
//   LOAD    | issuing in_addr 0..DEPTH-1 and capturing in_data one cycle later
//   PROCESS | DEPTH issue cycles into the transform stage plus one drain cycle
//   DONE    | results valid; held while start stays high
module block_xform_engine
  import block_xform_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 64,
  parameter int ADDR_W       = 8,
  parameter int LEVEL_OFFSET = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        state_out,
  output logic              busy,
  output logic              done,
  output logic              err_restart
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mode_t             mode_q, mode_d;
  logic              err_q, err_d;
  logic              last_start_q;
  logic              start_edge;
  logic              issue;

  logic [DATA_W-1:0] in_buf  [DEPTH];
  logic [DATA_W-1:0] out_buf [DEPTH];

  logic [DATA_W-1:0] u_y;
  logic              u_valid;
  logic [IDX_W-1:0]  u_idx;

  assign start_edge = start & ~last_start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_q       <= MODE_BYPASS;
      err_q        <= 1'b0;
      last_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      last_start_q <= start;
    end
  end

  // cnt_q runs 0..DEPTH in both LOAD and PROCESS; the final count is the
  // trailing capture (LOAD) or drain (PROCESS) cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    issue   = 1'b0;
    if (start_edge && state_q != IDLE) err_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = LOAD;
          cnt_d   = '0;
          mode_d  = mode_t'(mode);
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PROCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PROCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          issue = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_addr = '0;
    if (state_q == LOAD) in_addr = (cnt_q >= CNT_LAST) ? ADDR_LAST : ADDR_W'(cnt_q);
  end

  // Buffers carry no reset; their contents are meaningful only after a completed job.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && cnt_q != '0) in_buf[IDX_W'(cnt_q - CNT_W'(1))] <= in_data;
    if (state_q == PROCESS && u_valid) out_buf[u_idx] <= u_y;
  end

  block_xform_unit #(
    .DATA_W       (DATA_W),
    .LEVEL_OFFSET (LEVEL_OFFSET),
    .IDX_W        (IDX_W)
  ) u_unit (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_i  (mode_q),
    .x_i     (in_buf[IDX_W'(cnt_q)]),
    .valid_i (issue),
    .idx_i   (IDX_W'(cnt_q)),
    .y_o     (u_y),
    .valid_o (u_valid),
    .idx_o   (u_idx)
  );

  assign out_data    = ({1'b0, out_addr} < CNT_LAST) ? out_buf[IDX_W'(out_addr)] : '0;
  assign state_out   = state_q;
  assign busy        = (state_q == LOAD) || (state_q == PROCESS);
  assign done        = (state_q == DONE);
  assign err_restart = err_q;

endmodule

// File: tb/tb_block_xform_engine.sv
// Scoreboard bench for block_xform_engine: jobs push expected results and done times,
// a monitor reads the output buffer back whenever done rises and compares.
module tb_block_xform_engine;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;
  localparam int LVL    = 128;
  localparam int LAT    = 2 * DEPTH + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] out_addr = '0;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        state_out;
  logic              busy, done, err_restart;

  always #5 clk = ~clk;

  block_xform_engine #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEVEL_OFFSET(LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_addr(in_addr), .in_data(in_data),
    .out_addr(out_addr), .out_data(out_data),
    .state_out(state_out), .busy(busy), .done(done), .err_restart(err_restart)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle_cnt = 0;
  int rb_count = 0;
  logic exp_err = 1'b0;
  logic [DATA_W-1:0] src_mem [2**ADDR_W];
  logic [DATA_W-1:0] exp_q [$];
  int lat_q [$];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Reference transform from the arithmetic definition of each mode.
  function automatic logic [DATA_W-1:0] ref_xform(input int m, input logic [DATA_W-1:0] x);
    longint sx;
    case (m)
      0: return x;
      1: return ~x;
      2: begin
        sx = longint'(x) - longint'(LVL);
        return sx[DATA_W-1:0];
      end
      default: begin
        sx = longint'($signed(x));
        if (sx < 0) sx = -sx;
        return sx[DATA_W-1:0];
      end
    endcase
  endfunction

  // Source buffer with one cycle read latency.
  initial begin
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      a = in_addr;
      @(posedge clk);
      #1 in_data = src_mem[a];
    end
  end

  // Monitor: on every done rise, check latency and read the whole buffer back.
  initial begin
    logic dprev;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dprev) begin
        if (lat_q.size() == 0) note_fail("unexpected_done");
        else check("done_cycle", 64'(cycle_cnt), 64'(lat_q.pop_front()));
        for (int k = 0; k < DEPTH; k++) begin
          out_addr = ADDR_W'(k);
          #1;
          if (exp_q.size() == 0) note_fail("no_expected_data");
          else check($sformatf("out_data[%0d]", k), 64'(out_data), 64'(exp_q.pop_front()));
        end
        out_addr = ADDR_W'(DEPTH);
        #1;
        check("out_data_oob", 64'(out_data), 64'd0);
        out_addr = '0;
        rb_count++;
      end
      dprev = done;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (state_out != 4'd0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (state_out != 4'd0) note_fail("wait_idle_timeout");
  endtask

  task automatic fill_random();
    for (int k = 0; k < 2**ADDR_W; k++) src_mem[k] = $urandom;
  endtask

  task automatic run_job(input int m, input bit restart, input bit hold);
    int rb0;
    int t;
    @(negedge clk);
    wait_idle();
    check("err_before_accept", 64'(err_restart), 64'(exp_err));
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(ref_xform(m, src_mem[k]));
    mode = 2'(m);
    start = 1'b1;
    lat_q.push_back(cycle_cnt + LAT);
    rb0 = rb_count;
    @(negedge clk);
    mode = 2'($urandom);
    check("state_c1", 64'(state_out), 64'd1);
    check("busy_c1", 64'(busy), 64'd1);
    check("in_addr_c1", 64'(in_addr), 64'd0);
    check("err_cleared", 64'(err_restart), 64'd0);
    exp_err = 1'b0;
    if (restart) begin
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("err_restart_set", 64'(err_restart), 64'd1);
      check("restart_still_load", 64'(state_out), 64'd1);
      exp_err = 1'b1;
    end
    t = 0;
    while (rb_count == rb0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (rb_count == rb0) note_fail("done_timeout");
    @(negedge clk);
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        check("hold_state", 64'(state_out), 64'd3);
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_done", 64'(done), 64'd1);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_after_drop", 64'(state_out), 64'd0);
    check("done_after_drop", 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_random();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_restart), 64'd0);
    check("rst_in_addr", 64'(in_addr), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 2**ADDR_W; k++) src_mem[k] = DATA_W'(k * 3);
    run_job(0, 1'b0, 1'b1);

    fill_random();
    src_mem[5] = 32'h0000_00FF;
    run_job(1, 1'b0, 1'b0);

    fill_random();
    src_mem[0] = 32'd100;
    src_mem[1] = 32'd200;
    run_job(2, 1'b1, 1'b0);

    fill_random();
    src_mem[0] = 32'hFFFF_FFFF;
    src_mem[1] = 32'h8000_0000;
    src_mem[2] = 32'd7;
    run_job(3, 1'b0, 1'b0);

    repeat (4) begin
      fill_random();
      run_job(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort a job mid-PROCESS with a one-cycle reset.
    @(negedge clk);
    wait_idle();
    fill_random();
    mode = 2'd2;
    start = 1'b1;
    repeat (DEPTH + 10) @(negedge clk);
    check("pre_abort_state", 64'(state_out), 64'd2);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state", 64'(state_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_in_addr", 64'(in_addr), 64'd0);
    exp_err = 1'b0;

    fill_random();
    run_job(int'($urandom_range(0, 3)), 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("lat_q_drained", 64'(lat_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
